// File: rtl/companion_mood_fsm.sv
// companion_mood_fsm: registered companion mood with hysteresis, neglect counting and death; define COMPANION_MOOD_REVIVE_EN to allow leaving DEAD via revive
module companion_mood_fsm #(
    parameter int MAX_VALUE     = 10,
    parameter int LOW_THRESH    = 3,
    parameter int NEGLECT_LIMIT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [31:0] hunger,
    input  logic [31:0] energy,
    input  logic [31:0] fun,
    input  logic        revive,
    output logic [2:0]  mood,
    output logic        alive,
    output logic        alert,
    output logic [7:0]  neglect_count
);
    typedef enum logic [2:0] {
        HAPPY    = 3'd0,
        CONTENT  = 3'd1,
        NEEDY    = 3'd2,
        CRITICAL = 3'd3,
        DEAD     = 3'd4
    } mood_t;

    localparam logic [31:0] MAX_V     = 32'(MAX_VALUE);
    localparam logic [31:0] LOW_V     = 32'(LOW_THRESH);
    localparam logic [31:0] RECOVER_V = 32'(LOW_THRESH + 2);
    localparam logic [31:0] HAPPY_V   = 32'(MAX_VALUE - 1);
    localparam logic [31:0] CONTENT_V = 32'(MAX_VALUE - 3);
    localparam logic [7:0]  LIMIT     = 8'(NEGLECT_LIMIT);

    mood_t       state, state_next, prev;
    logic [7:0]  count_next;
    logic [31:0] h_c, e_c, f_c, m;
    logic        revive_hit;

`ifdef COMPANION_MOOD_REVIVE_EN
    assign revive_hit = revive;
`else
    logic unused_revive;
    assign unused_revive = revive;
    assign revive_hit    = 1'b0;
`endif

    assign mood = state;

    // Clamp every stat to the ceiling and take the weakest one
    always_comb begin
        h_c = hunger > MAX_V ? MAX_V : hunger;
        e_c = energy > MAX_V ? MAX_V : energy;
        f_c = fun > MAX_V ? MAX_V : fun;
        m   = h_c < e_c ? h_c : e_c;
        m   = f_c < m ? f_c : m;
    end

    // Prioritised mood rules; recovery thresholds differ from decline thresholds for hysteresis
    always_comb begin
        state_next = state;
        count_next = neglect_count;
        if (state == DEAD) begin
            if (revive_hit) begin
                state_next = CRITICAL;
                count_next = 8'd0;
            end
        end else if (m == 32'd0) begin
            state_next = CRITICAL;
            if (state == CRITICAL && tick) begin
                count_next = neglect_count + 8'd1;
                if (count_next == LIMIT) state_next = DEAD;
            end
        end else if (state == CRITICAL || state == NEEDY)
            state_next = m >= RECOVER_V ? (m >= HAPPY_V ? HAPPY : CONTENT) : NEEDY;
        else if (state == CONTENT)
            state_next = m <= LOW_V ? NEEDY : (m >= HAPPY_V ? HAPPY : CONTENT);
        else
            state_next = m <= LOW_V ? NEEDY : (m <= CONTENT_V ? CONTENT : HAPPY);
        if (state_next != CRITICAL && state_next != DEAD) count_next = 8'd0;
    end

    // State register; alert compares the registered mood with its previous value so it trails mood by a cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HAPPY;
            prev          <= HAPPY;
            alive         <= 1'b1;
            alert         <= 1'b0;
            neglect_count <= 8'd0;
        end else begin
            state         <= state_next;
            prev          <= state;
            alive         <= state_next != DEAD;
            neglect_count <= count_next;
            alert         <= state != prev && prev != DEAD &&
                             (state == NEEDY || state == CRITICAL || state == DEAD);
        end
    end
endmodule

// File: tb/tb_companion_mood_fsm.sv
// tb_companion_mood_fsm: scoreboard bench with a behavioural mood model (honours COMPANION_MOOD_REVIVE_EN)
module tb_companion_mood_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [31:0] hunger = 32'd10;
    logic [31:0] energy = 32'd10;
    logic [31:0] fun = 32'd10;
    logic        revive = 1'b0;
    logic [2:0]  mood;
    logic        alive;
    logic        alert;
    logic [7:0]  neglect_count;

`ifdef COMPANION_MOOD_REVIVE_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif
    localparam int LIMIT = 5;

    typedef struct {
        int md;
        bit alv;
        bit alr;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;

    int md = 0, prv = 0, cnt = 0;
    bit alv = 1'b1, alr = 1'b0;

    companion_mood_fsm dut (
        .clk(clk), .rst(rst), .tick(tick), .hunger(hunger), .energy(energy), .fun(fun),
        .revive(revive), .mood(mood), .alive(alive), .alert(alert), .neglect_count(neglect_count)
    );

    always #5 clk = ~clk;

    function automatic int clampv(int v);
        return v > 10 ? 10 : v;
    endfunction

    // Reference: mood as an integer 0..4, alert derived from the history of moods
    function automatic void model_step(bit r, bit t, bit v, int h, int e, int f);
        int m, nm, nc;
        m = clampv(h);
        if (clampv(e) < m) m = clampv(e);
        if (clampv(f) < m) m = clampv(f);
        if (r) begin
            md = 0; prv = 0; cnt = 0; alv = 1'b1; alr = 1'b0;
            return;
        end
        alr = (md != prv) && (md >= 2) && (prv != 4);
        prv = md;
        nm = md;
        nc = cnt;
        if (md == 4) begin
            if (REV_EN && v) begin nm = 3; nc = 0; end
        end else if (m == 0) begin
            nm = 3;
            if (md == 3 && t) begin
                nc = cnt + 1;
                if (nc == LIMIT) nm = 4;
            end
        end else if (md == 2 || md == 3) nm = (m >= 5) ? ((m >= 9) ? 0 : 1) : 2;
        else if (md == 1) nm = (m <= 3) ? 2 : ((m >= 9) ? 0 : 1);
        else nm = (m <= 3) ? 2 : ((m <= 7) ? 1 : 0);
        if (nm <= 2) nc = 0;
        md = nm;
        cnt = nc;
        alv = (md != 4);
    endfunction

    task automatic cyc(bit r, bit t, int h, int e, int f, bit v);
        exp_t x;
        @(negedge clk);
        rst = r; tick = t; revive = v;
        hunger = 32'(h); energy = 32'(e); fun = 32'(f);
        model_step(r, t, v, h, e, f);
        x.md = md; x.alv = alv; x.alr = alr; x.cnt = cnt;
        q.push_back(x);
    endtask

    task automatic idle(int n, int h, int e, int f);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, h, e, f, 1'b0);
    endtask

    task automatic starve_to_death();
        idle(2, 0, 10, 10);
        for (int i = 0; i < LIMIT; i++) begin
            cyc(1'b0, 1'b1, 0, 10, 10, 1'b0);
            idle(2, 0, 10, 10);
        end
    endtask

    function automatic void chk(string name, int act, int want);
        compared++;
        if (act != want) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, want);
        end
    endfunction

    function automatic int rstat();
        int k = $urandom_range(0, 7);
        return k == 0 ? 0 : (k == 1 ? $urandom_range(11, 100) : $urandom_range(0, 10));
    endfunction

    // Monitor: outputs are valid every cycle, so pop one expectation per edge once stimulus has started
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("mood", int'(mood), e.md);
            chk("alive", int'(alive), int'(e.alv));
            chk("alert", int'(alert), int'(e.alr));
            chk("neglect_count", int'(neglect_count), e.cnt);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode, h, e, f, waits;
        cyc(1'b1, 1'b0, 10, 10, 10, 1'b0);
        cyc(1'b1, 1'b0, 10, 10, 10, 1'b0);
        idle(2, 10, 10, 10);
        idle(3, 10, 10, 7);
        idle(3, 10, 10, 3);
        idle(3, 10, 10, 4);
        idle(3, 10, 10, 5);
        idle(3, 10, 10, 10);
        starve_to_death();
        idle(2, 0, 10, 10);
        cyc(1'b1, 1'b0, 0, 10, 10, 1'b0);
        idle(3, 10, 10, 10);
        idle(2, 0, 10, 10);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 0, 10, 10, 1'b0);
            idle(2, 0, 10, 10);
        end
        cyc(1'b0, 1'b1, 2, 10, 10, 1'b0);
        idle(3, 2, 10, 10);
        idle(3, 40, 12, 9);
        starve_to_death();
        cyc(1'b0, 1'b0, 0, 10, 10, 1'b1);
        idle(3, 0, 10, 10);
        mode = 0;
        for (int i = 0; i < 2500; i++) begin
            if (i % 40 == 0) mode = $urandom_range(0, 2);
            h = (mode == 1 && $urandom_range(0, 9) != 0) ? 0 : rstat();
            e = mode == 2 ? $urandom_range(0, 10) : rstat();
            f = mode == 2 ? $urandom_range(0, 10) : rstat();
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, h, e, f,
                $urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        rst = 1'b0; tick = 1'b0; revive = 1'b0;
        waits = 0;
        while (q.size() > 0 && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        if (q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
